eight_bit_4_1_rr_collector: RTL and testbench
=============================================

Name: eight_bit_4_1_rr_collector

Overview:
- Inverse of the 8-bit 1:4 demux path: merges four independent 8-bit source channels back onto one 8-bit stream.
- Each source has a valid/ready handshake, and a round-robin arbiter picks among them.
- The winning byte is registered into a single output stage, tagged with its channel number in the same s1/s0 encoding the demux uses.
- Sits at the collection end of the datapath, downstream of per-channel processing.

Parameters:
- WIDTH, 8, data width of every channel and of the output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in1, in2, in3, in4  input  WIDTH  source channel data (channel 0..3).
- valid1, valid2, valid3, valid4  input  1  source channel has a byte.
- ready1, ready2, ready3, ready4  output  1  byte on that channel is accepted this cycle (combinational).
- out  output  WIDTH  registered output byte.
- s0, s1  output  1  registered channel tag of out: {s1,s0}=00 for ch1, 01 for ch2, 10 for ch3, 11 for ch4.
- out_valid  output  1  out/s1/s0 hold a byte.
- out_ready  input  1  downstream accepts out this cycle.

Behaviour:
- Reset (synchronous, reset=1 at clk edge):
  - out=0, s1=s0=0, out_valid=0.
  - Round-robin pointer last=3 (ch4), so ch1 has first priority.
  - ready1..4=0 while reset is high.
- load_en = !out_valid | out_ready (output register empty or being drained this cycle).
- Arbitration (combinational):
  - Search order starts at (last+1) mod 4 and wraps; the first channel with validN=1 wins.
  - readyN=1 only for the winner, and only when load_en=1. At most one readyN is high per cycle.
  - No valid inputs: all readyN=0.
- Transfer: a byte moves on channel N when validN & readyN at the clk edge. On that edge:
  - out<=inN, {s1,s0}<=N-1, out_valid<=1, last<=N-1.
- Output drain:
  - out_valid & out_ready at an edge with no new winner: out_valid<=0. out/s1/s0 hold their old values.
  - With a new winner on the same edge: the register reloads and out_valid stays 1 (back-to-back, 1 byte/cycle).
- Stall: out_valid & !out_ready gives load_en=0, so all readyN=0. out/s1/s0/out_valid are held stable; no byte is lost or overwritten.
- Latency: a byte accepted at edge k appears on out with out_valid=1 during the cycle after edge k.
- Fairness:
  - last updates only on a transfer.
  - A continuously-valid channel is granted at least once every 4 transfers.
  - A single requester gets every slot.
- Sources must hold inN stable and validN asserted until their readyN handshake completes. The block does not check this.
- Reset mid-operation: a held output byte is discarded (out_valid=0), and the pointer returns to last=3 on the reset edge.
- Simultaneous events (drain + load, all four valid, wrap from ch4 to ch1) are handled by the rules above; there are no extra cases.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with valid1..4=1, in1..4=0x11/0x22/0x33/0x44 -> ready1..4=0, out_valid=0, out=0x00, {s1,s0}=00. First cycle after reset: ready1=1 only; next cycle out=0x11, {s1,s0}=00.
- All four valid, out_ready=1 constant, data held -> out sequence 0x11,0x22,0x33,0x44,0x11 on consecutive cycles. {s1,s0} sequence 00,01,10,11,00. out_valid stays 1.
- Backpressure: hold out=0x22 with out_ready=0 for 5 cycles -> out/s1/s0 stable, all readyN=0. out_ready=1 -> next byte 0x33 on the following cycle.
- Sparse fairness: only valid2 and valid4, each held high across 4 transfers, out_ready=1 -> grants alternate ch2,ch4,ch2,ch4 ({s1,s0}=01,11,01,11).
- Single requester: valid3 only, in3 incrementing 0x00..0x07 per accept -> out 0x00..0x07 back-to-back, {s1,s0}=10 throughout, ready3 high every cycle.
- Mid-stream reset: out_valid=1 holding 0x44 with out_ready=0; pulse reset one cycle -> out_valid=0, out=0x00. Next grant goes to ch1 if valid1=1.

Source files
------------

// File: rtl/eight_bit_4_1_rr_collector.sv
// rtl/eight_bit_4_1_rr_collector.sv - four-channel round-robin byte collector with registered output stage
module eight_bit_4_1_rr_collector #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic             valid1,
    input  logic             valid2,
    input  logic             valid3,
    input  logic             valid4,
    output logic             ready1,
    output logic             ready2,
    output logic             ready3,
    output logic             ready4,
    output logic [WIDTH-1:0] out,
    output logic             s0,
    output logic             s1,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [1:0]       tag_q, tag_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       last_q, last_d;

    logic [3:0]       valid_vec;
    logic [3:0]       ready_vec;
    logic [1:0]       grant_idx;
    logic             grant_any;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] grant_data;

    assign valid_vec = {valid4, valid3, valid2, valid1};

    // Search starts one past the last winner and wraps; first requester wins.
    always_comb begin
        logic [1:0] cand;
        grant_any = 1'b0;
        grant_idx = last_q + 2'd1;
        cand      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = last_q + 2'(i + 1);
            if (!grant_any && valid_vec[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        grant_data = in1;
        case (grant_idx)
            2'd0: grant_data = in1;
            2'd1: grant_data = in2;
            2'd2: grant_data = in3;
            2'd3: grant_data = in4;
            default: grant_data = in1;
        endcase
    end

    // The output register can take a byte when empty or being drained this cycle.
    assign load_en   = !out_valid_q || out_ready;
    assign xfer      = grant_any && load_en && !reset;
    assign ready_vec = xfer ? (4'b0001 << grant_idx) : 4'b0000;

    always_comb begin
        out_d       = out_q;
        tag_d       = tag_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (xfer) begin
            out_d       = grant_data;
            tag_d       = grant_idx;
            out_valid_d = 1'b1;
            last_d      = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            tag_q       <= 2'd0;
            out_valid_q <= 1'b0;
            last_q      <= 2'd3;
        end else begin
            out_q       <= out_d;
            tag_q       <= tag_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign ready1    = ready_vec[0];
    assign ready2    = ready_vec[1];
    assign ready3    = ready_vec[2];
    assign ready4    = ready_vec[3];
    assign out       = out_q;
    assign s1        = tag_q[1];
    assign s0        = tag_q[0];
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_eight_bit_4_1_rr_collector.sv
// tb/tb_eight_bit_4_1_rr_collector.sv - scoreboard bench for the round-robin collector
module tb_eight_bit_4_1_rr_collector;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in1, in2, in3, in4;
    logic       valid1, valid2, valid3, valid4;
    logic       ready1, ready2, ready3, ready4;
    logic [7:0] out;
    logic       s0, s1;
    logic       out_valid;
    logic       out_ready;

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q[$];

    eight_bit_4_1_rr_collector #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .valid1(valid1), .valid2(valid2), .valid3(valid3), .valid4(valid4),
        .ready1(ready1), .ready2(ready2), .ready3(ready3), .ready4(ready4),
        .out(out), .s0(s0), .s1(s1), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] tag, input logic [7:0] data);
        exp_q.push_back({tag, data});
    endtask

    // Each output byte is consumed exactly once, at the edge where out_valid & out_ready.
    task automatic monitor();
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {22'd0, s1, s0, out}, 32'h3ff);
                end else begin
                    e = exp_q.pop_front();
                    chk("scoreboard_byte", {22'd0, s1, s0, out}, {22'd0, e});
                end
            end
        end
    endtask

    function automatic logic [3:0] rdy();
        return {ready4, ready3, ready2, ready1};
    endfunction

    initial begin
        fork
            monitor();
        join_none

        reset = 1'b1; out_ready = 1'b1;
        in1 = 8'h11; in2 = 8'h22; in3 = 8'h33; in4 = 8'h44;
        {valid4, valid3, valid2, valid1} = 4'b1111;

        // Reset held two cycles with every source requesting
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("reset_ready", {28'd0, rdy()}, 32'h0);
            chk("reset_valid", {31'd0, out_valid}, 32'h0);
            chk("reset_out", {22'd0, s1, s0, out}, 32'h0);
        end
        reset = 1'b0;
        #1;
        chk("first_ready", {28'd0, rdy()}, 32'h1);

        // Rotation across all four, then a stall on 0x22
        push(2'b00, 8'h11); push(2'b01, 8'h22); push(2'b10, 8'h33);
        push(2'b11, 8'h44); push(2'b00, 8'h11); push(2'b01, 8'h22);
        cyc();
        chk("first_out", {22'd0, s1, s0, out}, {22'd0, 2'b00, 8'h11});
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rr_valid", {31'd0, out_valid}, 32'h1);
        end
        chk("pre_stall_out", {22'd0, s1, s0, out}, {22'd0, 2'b01, 8'h22});
        out_ready = 1'b0;
        #1;
        chk("stall_ready", {28'd0, rdy()}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_out", {21'd0, out_valid, s1, s0, out}, {21'd0, 1'b1, 2'b01, 8'h22});
            chk("stall_ready_hold", {28'd0, rdy()}, 32'h0);
        end
        out_ready = 1'b1;
        push(2'b10, 8'h33);
        #1;
        chk("resume_ready", {28'd0, rdy()}, 32'h4);
        cyc();
        chk("resume_out", {22'd0, s1, s0, out}, {22'd0, 2'b10, 8'h33});
        {valid4, valid3, valid2, valid1} = 4'b0000;
        cyc();
        chk("drain_empty", {21'd0, out_valid, s1, s0, out}, {21'd0, 1'b0, 2'b10, 8'h33});

        // Sparse fairness from a fresh pointer
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        {valid4, valid3, valid2, valid1} = 4'b1010;
        push(2'b01, 8'h22); push(2'b11, 8'h44); push(2'b01, 8'h22); push(2'b11, 8'h44);
        for (int i = 0; i < 4; i++) cyc();
        chk("sparse_last", {22'd0, s1, s0, out}, {22'd0, 2'b11, 8'h44});
        {valid4, valid3, valid2, valid1} = 4'b0000;
        cyc();

        // Single requester streams back-to-back
        valid3 = 1'b1;
        for (int i = 0; i < 8; i++) push(2'b10, 8'(i));
        for (int i = 0; i < 8; i++) begin
            in3 = 8'(i);
            #1;
            chk("single_ready3", {28'd0, rdy()}, 32'h4);
            cyc();
        end
        valid3 = 1'b0;
        in3 = 8'h33;
        cyc();

        // Mid-stream reset drops the held byte and restores ch1 priority
        out_ready = 1'b0;
        valid4 = 1'b1;
        cyc();
        valid4 = 1'b0;
        chk("held_44", {21'd0, out_valid, s1, s0, out}, {21'd0, 1'b1, 2'b11, 8'h44});
        reset = 1'b1;
        cyc();
        chk("midreset_out", {21'd0, out_valid, s1, s0, out}, 32'h0);
        reset = 1'b0;
        out_ready = 1'b1;
        {valid4, valid3, valid2, valid1} = 4'b1011;
        push(2'b00, 8'h11);
        #1;
        chk("post_reset_ready", {28'd0, rdy()}, 32'h1);
        cyc();
        {valid4, valid3, valid2, valid1} = 4'b0000;
        cyc();

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) cyc();
        chk("queue_empty", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
